// File: rtl/pdm_pkg.sv
// Shared constants and the saturating-add helper for the PDM modulator.
// Optional dither is enabled by defining PDM_MOD_DITHER_EN.
package pdm_pkg;

  localparam int OVERSAMPLE_DEF = 32;
  localparam int PCM_W_DEF      = 12;

  // Integrator headroom above the PCM width
  localparam int ACC1_GUARD = 4;
  localparam int ACC2_GUARD = 8;

  // Working width for intermediate sums, wide enough that they never wrap
  localparam int SAT_W = 48;
  localparam logic signed [SAT_W-1:0] SAT_ONE  = 48'sd1;
  localparam logic signed [SAT_W-1:0] SAT_ZERO = 48'sd0;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (SAT_ONE <<< (w - 1)) - SAT_ONE;
    lo  = -(SAT_ONE <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pdm_sd2.sv
// Second-order error-feedback sigma-delta core with saturating integrators.
// Defining PDM_MOD_DITHER_EN adds +/-1 LFSR dither ahead of the quantizer.
module pdm_sd2
  import pdm_pkg::*;
#(
  parameter int PCM_W = PCM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic signed [PCM_W-1:0] x,
  output logic                    y
);

  localparam int A1_W = PCM_W + ACC1_GUARD;
  localparam int A2_W = PCM_W + ACC2_GUARD;
  localparam logic signed [SAT_W-1:0] FS = SAT_ONE <<< (PCM_W - 1);

  logic signed [A1_W-1:0]  acc1_q, acc1_d;
  logic signed [A2_W-1:0]  acc2_q, acc2_d;
  logic                    y_q, y_d;
  logic signed [SAT_W-1:0] x_w, fb_w, s1, s2, q_w;

`ifdef PDM_MOD_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
`endif

  always_comb begin
    x_w  = SAT_W'(x);
    // Feedback comes from the previously emitted bit
    fb_w = y_q ? FS : -FS;
    s1   = sat_add(SAT_W'(acc1_q), x_w - fb_w, A1_W);
    s2   = sat_add(SAT_W'(acc2_q), s1 - fb_w, A2_W);
`ifdef PDM_MOD_DITHER_EN
    q_w    = s2 + (lfsr_q[0] ? SAT_ONE : -SAT_ONE);
    lfsr_d = lfsr_q;
    if (we) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
`else
    q_w = s2;
`endif
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    y_d    = y_q;
    if (we) begin
      acc1_d = s1[A1_W-1:0];
      acc2_d = s2[A2_W-1:0];
      y_d    = (q_w >= SAT_ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
      y_q    <= 1'b0;
`ifdef PDM_MOD_DITHER_EN
      lfsr_q <= LFSR_SEED;
`endif
    end else begin
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
      y_q    <= y_d;
`ifdef PDM_MOD_DITHER_EN
      lfsr_q <= lfsr_d;
`endif
    end
  end

  assign y = y_q;

endmodule

// File: rtl/pdm_mod.sv
// PCM-to-PDM modulator top: sample handshake, oversampling phase counter, sample registers.
// PDM_MOD_DITHER_EN (see pdm_sd2) enables quantizer dither.
module pdm_mod
  import pdm_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PCM_W      = PCM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic signed [PCM_W-1:0] pcm_in,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    pdm_out,
  output logic                    underrun
);

  localparam int PH_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [PCM_W-1:0] hold_q, hold_d;
  logic signed [PCM_W-1:0] cur_q, cur_d;
  logic                    hold_full_q, hold_full_d;
  logic                    underrun_q, underrun_d;
  logic                    accept, boundary, bypass;

  assign pcm_ready = !hold_full_q;
  assign accept    = pcm_valid && pcm_ready;
  assign boundary  = we && (phase_q == PH_LAST);
  assign bypass    = boundary && !hold_full_q && accept;

  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cur_d       = cur_q;
    underrun_d  = underrun_q;
    if (we) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    if (boundary) begin
      if (hold_full_q) begin
        cur_d       = hold_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        cur_d = pcm_in;
      end else begin
        underrun_d = 1'b1;
      end
    end
    // A bypassed sample goes straight to cur and leaves hold empty
    if (accept && !bypass) begin
      hold_d      = pcm_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cur_q       <= '0;
      underrun_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cur_q       <= cur_d;
      underrun_q  <= underrun_d;
    end
  end

  assign underrun = underrun_q;

  pdm_sd2 #(
    .PCM_W(PCM_W)
  ) u_sd2 (
    .clk(clk),
    .rst(rst),
    .we (we),
    .x  (cur_q),
    .y  (pdm_out)
  );

endmodule
